waveform_lut_loader: RTL and testbench
======================================

# waveform_lut_loader

Stream-to-LUT loader that fills the coefficient table consumed by the quarter-wave LUT waveform generator when that generator is built with external LUT access. It accepts magnitude samples over a valid/ready stream, packs them into the flat `LUT_ROM` bus, checks frame length, and raises `LUT_READY` once a complete, consistent quarter-wave table is held. It sits between the host/config path and the generator, whose `EN` is normally driven from `LUT_READY`.

## Interface

- `LUT_WIDTH`, default 32: number of quarter-wave entries.
- `BIT_WIDTH`, default 16: generator output width. Each stored entry is `DW = BIT_WIDTH-1` bits.

- `CLK_SYS`  in  1  system clock; all logic on the rising edge.
- `RST`  in  1  synchronous reset, active-high.
- `START`  in  1  one-cycle pulse that begins a new load from any state.
- `S_DATA`  in  DW  unsigned sample magnitude.
- `S_VALID`  in  1  sample valid.
- `S_LAST`  in  1  marks the final sample of the frame; qualified by the handshake.
- `S_READY`  out  1  loader accepts a sample.
- `LUT_ROM`  out  DW*LUT_WIDTH  packed table; entry i sits at `[i*DW +: DW]`.
- `LUT_READY`  out  1  table complete and valid.
- `BUSY`  out  1  state is LOAD.
- `ERR_LEN`  out  1  frame length error (sticky until START or RST).
- `ERR_MONO`  out  1  monotonicity error (sticky until START or RST).
- `WR_CNT`  out  $clog2(LUT_WIDTH+1)  number of entries accepted in the current load.

## Operation

- **States:** IDLE, LOAD, DONE, ERROR. Reset enters IDLE.
- **Reset values:** `LUT_ROM`=0, `WR_CNT`=0, `LUT_READY`=0, `BUSY`=0, `ERR_LEN`=0, `ERR_MONO`=0.
- **Ready:** `S_READY = (state==LOAD) && !START`. This is combinational, so a beat offered in a START cycle is never accepted.
- **START from any state:**
  - Next state is LOAD.
  - `WR_CNT`←0.
  - `ERR_*`←0.
  - `LUT_READY`←0.
  - `LUT_ROM` keeps its old contents and is overwritten entry by entry.
- **LOAD handshake (`S_VALID && S_READY`):**
  - Write `S_DATA` to entry `WR_CNT`.
  - `WR_CNT` increments.
  - Record the previous sample.
- **Length check:**
  - `S_LAST` on a beat with `WR_CNT < LUT_WIDTH-1` → `ERR_LEN`=1 and next state ERROR. The beat is still written.
  - Beat at `WR_CNT == LUT_WIDTH-1` without `S_LAST` → `ERR_LEN`=1, ERROR.
  - Beat at `WR_CNT == LUT_WIDTH-1` with `S_LAST` → DONE.
- **DONE:** `LUT_READY`=1, `S_READY`=0. Only START leaves this state.
- **ERROR:** `LUT_READY`=0, `S_READY`=0, error flags held. Only START leaves this state.
- **IDLE:** `S_READY`=0. Beats are ignored and `S_LAST` is ignored.
- **Error priority:** if the length and monotonicity checks fail on the same beat, both flags set.
- **RST mid-load:** returns to IDLE and clears `LUT_ROM` to 0.

## Timing

- Entry register updates on the handshake edge. `WR_CNT` is visible the next cycle.
- `LUT_READY` rises on the first cycle after the final handshake, with all of `LUT_ROM` already stable.
- `ERR_*` and the ERROR state are visible the cycle after the offending beat.
- `LUT_READY` falls the cycle after START.
- `BUSY` equals `state==LOAD` and is registered.
- Sustained throughput is one sample per cycle. A full load takes `LUT_WIDTH` cycles plus 1.

## Configuration

- **`LUT_LOADER_MONO_CHECK_EN` defined:**
  - A handshake beat, other than the first of a frame, with `S_DATA` strictly less than the previous sample sets `ERR_MONO`=1 and moves to ERROR.
  - Equal values are legal.
  - Rationale: the generator assumes a non-decreasing quarter wave.
- **Not defined:** no comparator or previous-sample register is built, and `ERR_MONO` is tied to 0.

## Test plan

All scenarios use LUT_WIDTH=4 and BIT_WIDTH=8 (DW=7).

- **Nominal load:** START, then beats 0, 10, 20, 30 with `S_LAST` on the 4th, one per cycle → `LUT_ROM`=28'h3C50500, `LUT_READY`=1 one cycle after the last beat, `WR_CNT`=4, no errors.
- **Backpressure and gaps:** same data with `S_VALID` toggling 1,0,0,1… → identical `LUT_ROM`, `WR_CNT` advances only on handshakes, and `S_READY` stays 1 throughout LOAD.
- **Short frame:** beats 5, 6 with `S_LAST` on the 2nd → `ERR_LEN`=1, `LUT_READY`=0, `S_READY`=0, `WR_CNT`=2. A following START clears `ERR_LEN`.
- **Long frame:** four beats with no `S_LAST` → `ERR_LEN`=1 after the 4th beat, and a 5th beat is not accepted.
- **Monotonic violation** (macro on): beats 0, 20, 10, … → `ERR_MONO`=1 after the 3rd beat and state ERROR. With the macro off, the same stimulus completes with `LUT_READY`=1 and `ERR_MONO`=0.
- **START/RST mid-operation:**
  - START after 2 beats, with a beat offered in the same cycle → that beat is not accepted and `WR_CNT`=0.
  - A full reload then gives the new table.
  - RST asserted in DONE → `LUT_ROM`=0 and `LUT_READY`=0 on the next edge.

Source files
------------

// File: rtl/waveform_lut_loader_if.sv
// Sample stream between the host/config path and waveform_lut_loader.
// The master drives magnitude samples; the slave (the loader) returns S_READY.
interface waveform_lut_loader_if #(
    parameter int DW = 15
);
    logic [DW-1:0] S_DATA;
    logic          S_VALID;
    logic          S_LAST;
    logic          S_READY;

    modport master (output S_DATA, output S_VALID, output S_LAST, input S_READY);
    modport slave  (input S_DATA, input S_VALID, input S_LAST, output S_READY);
endinterface

// File: rtl/waveform_lut_loader.sv
// waveform_lut_loader: fills the quarter-wave coefficient table of the LUT
// waveform generator from a valid/ready sample stream, checks frame length
// and raises LUT_READY once a complete table is held.
// Optional feature: define LUT_LOADER_MONO_CHECK_EN to reject frames whose
// samples decrease (ERR_MONO); without it ERR_MONO is always 0.
module waveform_lut_loader #(
    parameter int  LUT_WIDTH = 32,
    parameter int  BIT_WIDTH = 16,
    localparam int DW        = BIT_WIDTH - 1,
    localparam int CW        = $clog2(LUT_WIDTH + 1)
) (
    input  logic                    CLK_SYS,
    input  logic                    RST,
    input  logic                    START,
    waveform_lut_loader_if.slave    s_if,
    output logic [DW*LUT_WIDTH-1:0] LUT_ROM,
    output logic                    LUT_READY,
    output logic                    BUSY,
    output logic                    ERR_LEN,
    output logic                    ERR_MONO,
    output logic [CW-1:0]           WR_CNT
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(LUT_WIDTH - 1);

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   wr_cnt_q;
    logic            err_len_q;
    logic            err_mono_q;
    logic [DW-1:0]   lut_q [LUT_WIDTH];
    logic            beat;
    logic            at_last_idx;
    logic            len_bad;
    logic            mono_bad;

    // A beat offered together with START is never taken.
    assign s_if.S_READY = (state_q == LOAD) && !START;
    assign beat         = s_if.S_VALID && s_if.S_READY;
    assign at_last_idx  = (wr_cnt_q == LAST_IDX);
    // S_LAST must appear exactly on the final entry.
    assign len_bad      = at_last_idx ? !s_if.S_LAST : s_if.S_LAST;

`ifdef LUT_LOADER_MONO_CHECK_EN
    logic [DW-1:0] prev_q;

    // Remember the last accepted sample for the non-decreasing check.
    always_ff @(posedge CLK_SYS) begin
        if (beat) begin
            prev_q <= s_if.S_DATA;
        end
    end

    // The first beat of a frame has no predecessor and is never flagged.
    assign mono_bad = (wr_cnt_q != '0) && (s_if.S_DATA < prev_q);
`else
    assign mono_bad = 1'b0;
`endif

    // Next-state: START wins from anywhere; a load ends on error or last entry.
    always_comb begin
        state_d = state_q;
        if (START) begin
            state_d = LOAD;
        end else if ((state_q == LOAD) && beat) begin
            if (len_bad || mono_bad) begin
                state_d = ERROR;
            end else if (at_last_idx) begin
                state_d = DONE;
            end
        end
    end

    // State, write counter and sticky error flags.
    always_ff @(posedge CLK_SYS) begin
        if (RST) begin
            state_q    <= IDLE;
            wr_cnt_q   <= '0;
            err_len_q  <= 1'b0;
            err_mono_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (START) begin
                wr_cnt_q   <= '0;
                err_len_q  <= 1'b0;
                err_mono_q <= 1'b0;
            end else if (beat) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
                if (len_bad) begin
                    err_len_q <= 1'b1;
                end
                if (mono_bad) begin
                    err_mono_q <= 1'b1;
                end
            end
        end
    end

    // Table storage: each accepted beat lands in entry WR_CNT, even an erroneous one.
    always_ff @(posedge CLK_SYS) begin
        if (RST) begin
            for (int i = 0; i < LUT_WIDTH; i++) begin
                lut_q[i] <= '0;
            end
        end else if (beat) begin
            for (int i = 0; i < LUT_WIDTH; i++) begin
                if (wr_cnt_q == CW'(i)) begin
                    lut_q[i] <= s_if.S_DATA;
                end
            end
        end
    end

    for (genvar g = 0; g < LUT_WIDTH; g++) begin : g_pack
        assign LUT_ROM[g*DW +: DW] = lut_q[g];
    end

    assign LUT_READY = (state_q == DONE);
    assign BUSY      = (state_q == LOAD);
    assign ERR_LEN   = err_len_q;
    assign ERR_MONO  = err_mono_q;
    assign WR_CNT    = wr_cnt_q;

endmodule

// File: tb/tb_waveform_lut_loader.sv
// Bench for waveform_lut_loader at LUT_WIDTH=4, BIT_WIDTH=8. Each frame is
// scored by a frame-level reference that applies the loader's length and
// ordering rules to the whole list of beats.
module tb_waveform_lut_loader;
    localparam int LW = 4;
    localparam int BW = 8;
    localparam int DW = BW - 1;
    localparam int CW = $clog2(LW + 1);
`ifdef LUT_LOADER_MONO_CHECK_EN
    localparam bit MONO = 1'b1;
`else
    localparam bit MONO = 1'b0;
`endif

    logic             CLK_SYS = 1'b0;
    logic             RST;
    logic             START;
    logic [DW*LW-1:0] LUT_ROM;
    logic             LUT_READY;
    logic             BUSY;
    logic             ERR_LEN;
    logic             ERR_MONO;
    logic [CW-1:0]    WR_CNT;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] m_rom [LW];

    waveform_lut_loader_if #(.DW(DW)) sif ();

    waveform_lut_loader #(.LUT_WIDTH(LW), .BIT_WIDTH(BW)) dut (
        .CLK_SYS   (CLK_SYS),
        .RST       (RST),
        .START     (START),
        .s_if      (sif.slave),
        .LUT_ROM   (LUT_ROM),
        .LUT_READY (LUT_READY),
        .BUSY      (BUSY),
        .ERR_LEN   (ERR_LEN),
        .ERR_MONO  (ERR_MONO),
        .WR_CNT    (WR_CNT)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    task automatic tick();
        @(posedge CLK_SYS);
        #1;
    endtask

    function automatic logic [DW*LW-1:0] model_rom();
        logic [DW*LW-1:0] r;
        r = '0;
        for (int i = 0; i < LW; i++) r[i*DW +: DW] = m_rom[i];
        return r;
    endfunction

    // Pulse START (optionally offering a beat in the same cycle) and check the restart.
    task automatic do_start(input bit offer, input string tag);
        START = 1'b1;
        sif.S_VALID = offer;
        sif.S_DATA = DW'($urandom);
        sif.S_LAST = 1'($urandom);
        @(negedge CLK_SYS);
        total++; if (sif.S_READY !== 1'b0) begin bad++; $display("FAIL %s_start_ready: got %0b want 0", tag, sif.S_READY); end
        tick();
        START = 1'b0;
        sif.S_VALID = 1'b0;
        sif.S_LAST = 1'b0;
        total++; if (WR_CNT !== CW'(0)) begin bad++; $display("FAIL %s_start_cnt: got %0d want 0", tag, WR_CNT); end
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL %s_start_busy: got %0b want 1", tag, BUSY); end
        total++; if (LUT_READY !== 1'b0) begin bad++; $display("FAIL %s_start_lutrdy: got %0b want 0", tag, LUT_READY); end
        total++; if ({ERR_LEN, ERR_MONO} !== 2'b00) begin bad++; $display("FAIL %s_start_err: got %0b%0b want 00", tag, ERR_LEN, ERR_MONO); end
        total++; if (LUT_ROM !== model_rom()) begin bad++; $display("FAIL %s_start_rom: got %0h want %0h", tag, LUT_ROM, model_rom()); end
    endtask

    // Offer n beats after a START; gap_mode 0 = back to back, 1 = valid 1,0,0,1..., 2 = random gaps.
    task automatic send_frame(input logic [DW-1:0] d [6], input bit l [6], input int n,
                              input int gap_mode, input string tag);
        int  n_acc;
        int  gaps;
        int  exp_cnt;
        bit  e_len;
        bit  e_mono;
        bit  done;
        bit  loading;
        n_acc = n; e_len = 0; e_mono = 0; done = 0;
        for (int i = 0; i < n; i++) begin
            m_rom[i] = d[i];
            if (MONO && i > 0 && d[i] < d[i-1]) e_mono = 1;
            if (l[i] && i < LW-1) e_len = 1;
            if (i == LW-1 && !l[i]) e_len = 1;
            if (e_len || e_mono || i == LW-1) begin
                done = !(e_len || e_mono);
                n_acc = i + 1;
                break;
            end
        end
        loading = !(done || e_len || e_mono);
        for (int k = 0; k < n; k++) begin
            gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? ((k == 0) ? 0 : 2) : $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                sif.S_VALID = 1'b0;
                sif.S_DATA = DW'($urandom);
                sif.S_LAST = 1'($urandom);
                @(negedge CLK_SYS);
                total++; if (sif.S_READY !== 1'(k < n_acc)) begin bad++; $display("FAIL %s_gap_ready%0d: got %0b want %0b", tag, k, sif.S_READY, k < n_acc); end
                tick();
                exp_cnt = (k < n_acc) ? k : n_acc;
                total++; if (WR_CNT !== CW'(exp_cnt)) begin bad++; $display("FAIL %s_gap_cnt%0d: got %0d want %0d", tag, k, WR_CNT, exp_cnt); end
            end
            sif.S_VALID = 1'b1;
            sif.S_DATA = d[k];
            sif.S_LAST = l[k];
            @(negedge CLK_SYS);
            total++; if (sif.S_READY !== 1'(k < n_acc)) begin bad++; $display("FAIL %s_ready%0d: got %0b want %0b", tag, k, sif.S_READY, k < n_acc); end
            tick();
            exp_cnt = (k < n_acc) ? k + 1 : n_acc;
            total++; if (WR_CNT !== CW'(exp_cnt)) begin bad++; $display("FAIL %s_cnt%0d: got %0d want %0d", tag, k, WR_CNT, exp_cnt); end
        end
        sif.S_VALID = 1'b0;
        sif.S_LAST = 1'b0;
        total++; if (LUT_ROM !== model_rom()) begin bad++; $display("FAIL %s_rom: got %0h want %0h", tag, LUT_ROM, model_rom()); end
        total++; if (LUT_READY !== done) begin bad++; $display("FAIL %s_lutrdy: got %0b want %0b", tag, LUT_READY, done); end
        total++; if (BUSY !== loading) begin bad++; $display("FAIL %s_busy: got %0b want %0b", tag, BUSY, loading); end
        total++; if (sif.S_READY !== loading) begin bad++; $display("FAIL %s_sready: got %0b want %0b", tag, sif.S_READY, loading); end
        total++; if (ERR_LEN !== e_len) begin bad++; $display("FAIL %s_errlen: got %0b want %0b", tag, ERR_LEN, e_len); end
        total++; if (ERR_MONO !== e_mono) begin bad++; $display("FAIL %s_errmono: got %0b want %0b", tag, ERR_MONO, e_mono); end
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b0;
        sif.S_VALID = 1'b0; sif.S_DATA = '0; sif.S_LAST = 1'b0;
        for (int i = 0; i < LW; i++) m_rom[i] = '0;
        tick(); tick();
        total++; if (LUT_ROM !== '0) begin bad++; $display("FAIL rst_rom: got %0h want 0", LUT_ROM); end
        total++; if (WR_CNT !== CW'(0)) begin bad++; $display("FAIL rst_cnt: got %0d want 0", WR_CNT); end
        total++; if ({LUT_READY, BUSY, ERR_LEN, ERR_MONO} !== 4'b0000) begin bad++; $display("FAIL rst_flags: got %0b%0b%0b%0b want 0000", LUT_READY, BUSY, ERR_LEN, ERR_MONO); end
        total++; if (sif.S_READY !== 1'b0) begin bad++; $display("FAIL rst_sready: got %0b want 0", sif.S_READY); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        logic [DW-1:0] d [6];
        bit l [6];
        d = '{7'd0, 7'd10, 7'd20, 7'd30, 7'd0, 7'd0};
        l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_start(1'b0, "nom");
        send_frame(d, l, 4, 0, "nom");
        total++; if (LUT_ROM !== 28'h3C50500) begin bad++; $display("FAIL nom_const: got %0h want 3c50500", LUT_ROM); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d [6];
        bit l [6];
        d = '{7'd0, 7'd10, 7'd20, 7'd30, 7'd0, 7'd0};
        l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_start(1'b1, "bp");
        send_frame(d, l, 4, 1, "bp");
        total++; if (LUT_ROM !== 28'h3C50500) begin bad++; $display("FAIL bp_const: got %0h want 3c50500", LUT_ROM); end
    endtask

    task automatic test_short_frame();
        logic [DW-1:0] d [6];
        bit l [6];
        d = '{7'd5, 7'd6, 7'd0, 7'd0, 7'd0, 7'd0};
        l = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        do_start(1'b0, "short");
        send_frame(d, l, 2, 0, "short");
        do_start(1'b0, "short_clr");
    endtask

    task automatic test_long_frame();
        logic [DW-1:0] d [6];
        bit l [6];
        d = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd0};
        l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_start(1'b0, "long");
        send_frame(d, l, 5, 0, "long");
    endtask

    task automatic test_mono();
        logic [DW-1:0] d [6];
        bit l [6];
        d = '{7'd0, 7'd20, 7'd10, 7'd30, 7'd0, 7'd0};
        l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_start(1'b0, "mono");
        send_frame(d, l, 4, 0, "mono");
    endtask

    task automatic test_start_mid();
        logic [DW-1:0] d [6];
        bit l [6];
        d = '{7'd40, 7'd41, 7'd0, 7'd0, 7'd0, 7'd0};
        l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_start(1'b0, "mid");
        send_frame(d, l, 2, 0, "mid_part");
        do_start(1'b1, "mid_restart");
        d = '{7'd3, 7'd33, 7'd66, 7'd99, 7'd0, 7'd0};
        l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        send_frame(d, l, 4, 0, "mid_reload");
    endtask

    task automatic test_rst_done();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < LW; i++) m_rom[i] = '0;
        total++; if (LUT_ROM !== '0) begin bad++; $display("FAIL rstd_rom: got %0h want 0", LUT_ROM); end
        total++; if (LUT_READY !== 1'b0) begin bad++; $display("FAIL rstd_lutrdy: got %0b want 0", LUT_READY); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rstd_busy: got %0b want 0", BUSY); end
        sif.S_VALID = 1'b1; sif.S_DATA = 7'd55; sif.S_LAST = 1'b1;
        @(negedge CLK_SYS);
        total++; if (sif.S_READY !== 1'b0) begin bad++; $display("FAIL idle_ready: got %0b want 0", sif.S_READY); end
        tick();
        sif.S_VALID = 1'b0; sif.S_LAST = 1'b0;
        total++; if (WR_CNT !== CW'(0)) begin bad++; $display("FAIL idle_cnt: got %0d want 0", WR_CNT); end
        total++; if ({LUT_READY, ERR_LEN} !== 2'b00) begin bad++; $display("FAIL idle_flags: got %0b%0b want 00", LUT_READY, ERR_LEN); end
        total++; if (LUT_ROM !== '0) begin bad++; $display("FAIL idle_rom: got %0h want 0", LUT_ROM); end
    endtask

    task automatic test_random();
        logic [DW-1:0] d [6];
        bit l [6];
        int n;
        for (int it = 0; it < 30; it++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < 6; i++) begin
                d[i] = DW'($urandom);
                l[i] = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 1) == 1) begin
                n = LW;
                for (int i = 0; i < LW; i++) l[i] = (i == LW-1);
                for (int i = 1; i < LW; i++) if (d[i] < d[i-1] && $urandom_range(0, 2) != 0) d[i] = d[i-1];
            end
            do_start(1'($urandom), "rnd");
            send_frame(d, l, n, 2, "rnd");
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_short_frame();
        test_long_frame();
        test_mono();
        test_start_mid();
        test_rst_done();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
